// File: rtl/memory_bus_arbiter_pkg.sv
// Shared types for the multi-core memory bus arbiter: FSM states, physical
// address type and the latched request record.
package memory_bus_pkg;

  localparam int PHYS_ADDR_W   = 21;
  localparam int MAX_DATA_W    = 64;
  localparam int MAX_CORE_ID_W = 4;

  typedef logic [PHYS_ADDR_W-1:0] phys_memory_address_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic                     write;
    phys_memory_address_t     addr;
    logic [MAX_DATA_W-1:0]    wdata;
    logic [MAX_CORE_ID_W-1:0] core;
  } mem_req_t;

  // Width of a core index; a single core still needs one bit.
  function automatic int core_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/memory_bus_arbiter_if.sv
// Per-core request/response channels plus the shared DRAM bus, as seen by the
// arbiter (slave) and by the cores/DRAM around it (master).
interface memory_bus_arbiter_if #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 21,
  parameter int DATA_W    = 64
);
  localparam int CORE_ID_W = memory_bus_pkg::core_id_w(NUM_CORES);

  logic [NUM_CORES-1:0]        req_valid;
  logic [NUM_CORES-1:0]        req_ready;
  logic [NUM_CORES-1:0]        req_write;
  logic [NUM_CORES*ADDR_W-1:0] req_addr;
  logic [NUM_CORES*DATA_W-1:0] req_wdata;
  logic [NUM_CORES-1:0]        resp_valid;
  logic                        resp_err;
  logic [DATA_W-1:0]           resp_rdata;
  logic                        mem_req_valid;
  logic                        mem_req_ready;
  logic                        mem_req_write;
  logic [ADDR_W-1:0]           mem_req_addr;
  logic [DATA_W-1:0]           mem_req_wdata;
  logic [CORE_ID_W-1:0]        mem_req_core;
  logic                        mem_resp_valid;
  logic [DATA_W-1:0]           mem_resp_rdata;
  logic                        busy;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_core,
    output busy
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_core,
    input  busy
  );

endinterface

// File: rtl/memory_bus_arbiter_rr_priority_picker.sv
// Round-robin priority picker: first asserted request scanning from rr_ptr
// upward, wrapping modulo NUM_CORES. Purely combinational.
module rr_priority_picker #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = memory_bus_pkg::core_id_w(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [NUM_CORES-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx
);

  // One spare bit so rr_ptr + i can exceed NUM_CORES-1 before wrapping.
  logic [IDX_W:0] pos;
  logic           found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      pos = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(NUM_CORES)) pos = pos - (IDX_W+1)'(NUM_CORES);
      if (!found && req[pos[IDX_W-1:0]]) begin
        found                  = 1'b1;
        grant[pos[IDX_W-1:0]]  = 1'b1;
        grant_idx              = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter of NUM_CORES request channels onto one DRAM bus with a
// single outstanding transaction and a per-transaction response timeout.
module memory_bus_arbiter import memory_bus_pkg::*; #(
  parameter int NUM_CORES      = 4,
  parameter int ADDR_W         = 21,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                 clk,
  input logic                 reset,
  memory_bus_arbiter_if.slave bus
);

  localparam int IDX_W = core_id_w(NUM_CORES);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  if (ADDR_W != PHYS_ADDR_W || DATA_W > MAX_DATA_W || NUM_CORES < 1 || NUM_CORES > 16)
  begin : g_bad_params
    $error("memory_bus_arbiter: unsupported ADDR_W/DATA_W/NUM_CORES");
  end

  arb_state_t           state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     rr_next;
  logic [CNT_W-1:0]     cnt;
  logic                 err_q;
  mem_req_t             req_q;
  logic [DATA_W-1:0]    rdata_q;
  logic [NUM_CORES-1:0] grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 handshake;

  rr_priority_picker #(.NUM_CORES(NUM_CORES), .IDX_W(IDX_W)) u_picker (
    .req       (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign handshake = (state == IDLE) && (|bus.req_valid);

  always_comb begin
    rr_next = IDX_W'(req_q.core + 1'b1);
    if (req_q.core >= MAX_CORE_ID_W'(NUM_CORES - 1)) rr_next = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (handshake) state <= ISSUE;
        ISSUE: if (bus.mem_req_ready) begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // A response arriving in the expiry cycle takes precedence over the timeout.
          if (bus.mem_resp_valid) begin
            err_q <= 1'b0;
            state <= RESPOND;
          end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_LAST) begin
            err_q <= 1'b1;
            state <= RESPOND;
          end
        end
        RESPOND: begin
          rr_ptr <= rr_next;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Owner (core field) is the only part of the latch that is reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q.core <= '0;
    end else if (handshake) begin
      req_q <= '{write: bus.req_write[grant_idx],
                 addr:  bus.req_addr[grant_idx*ADDR_W +: ADDR_W],
                 wdata: MAX_DATA_W'(bus.req_wdata[grant_idx*DATA_W +: DATA_W]),
                 core:  MAX_CORE_ID_W'(grant_idx)};
    end
  end

  always_ff @(posedge clk) begin
    if (state == WAIT) rdata_q <= bus.mem_resp_valid ? bus.mem_resp_rdata : '0;
  end

  // Every output is qualified by state, so unreset datapath latches never leak out.
  assign bus.req_ready     = (state == IDLE) ? grant : '0;
  assign bus.mem_req_valid = (state == ISSUE);
  assign bus.mem_req_write = (state == ISSUE) && req_q.write;
  assign bus.mem_req_addr  = (state == ISSUE) ? req_q.addr : '0;
  assign bus.mem_req_wdata = (state == ISSUE) ? req_q.wdata[DATA_W-1:0] : '0;
  assign bus.mem_req_core  = (state == ISSUE) ? req_q.core[IDX_W-1:0] : '0;
  assign bus.resp_valid    = (state == RESPOND) ? (NUM_CORES'(1) << req_q.core) : '0;
  assign bus.resp_err      = (state == RESPOND) && err_q;
  assign bus.resp_rdata    = (state == RESPOND) ? rdata_q : '0;
  assign bus.busy          = (state != IDLE);

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Bench for memory_bus_arbiter: directed scenarios plus randomized transactions
// checked against a round-robin / timeout reference model.
module tb_memory_bus_arbiter;

  localparam int NC = 4;
  localparam int AW = 21;
  localparam int DW = 64;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  memory_bus_arbiter_if #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) bus ();

  memory_bus_arbiter #(
    .NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int ptr    = 0;
  logic [AW-1:0] addr_m  [NC];
  logic [DW-1:0] wdata_m [NC];
  logic          wr_m    [NC];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: first requesting core at or after the pointer, wrapping.
  function automatic int pick(input logic [NC-1:0] r, input int p);
    for (int k = 0; k < NC; k++)
      if (r[(p + k) % NC]) return (p + k) % NC;
    return -1;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, " quiet"}, {60'd0, bus.busy, bus.mem_req_valid, bus.resp_err, |bus.resp_valid}, 64'd0);
  endtask

  // One full transaction. k = WAIT cycle index in which DRAM responds; k >= TO
  // means DRAM is silent until after the timeout (then responds late in IDLE).
  task automatic txn(input logic [NC-1:0] reqs, input int rdy_dly, input int k,
                     input bit fixed, input string tag);
    int w;
    int endi;
    bit to;
    logic [DW-1:0] rd;
    w = pick(reqs, ptr);
    for (int i = 0; i < NC; i++) begin
      addr_m[i]  = AW'($urandom);
      wdata_m[i] = {$urandom, $urandom};
      wr_m[i]    = 1'($urandom);
      if (fixed) begin
        addr_m[i] = 21'h000100;
        wr_m[i]   = 1'b0;
      end
      bus.req_addr[i*AW +: AW]  = addr_m[i];
      bus.req_wdata[i*DW +: DW] = wdata_m[i];
      bus.req_write[i]          = wr_m[i];
    end
    rd = fixed ? 64'hDEADBEEF_CAFEF00D : {$urandom, $urandom};
    bus.req_valid = reqs;
    #1;
    chk({tag, " grant"}, 64'(bus.req_ready), 64'(1) << w);
    tick();
    bus.req_valid = '0;
    chk({tag, " issue ctl"}, {bus.mem_req_valid, bus.mem_req_write, 2'(bus.mem_req_core), 4'(bus.req_ready)},
        {1'b1, wr_m[w], 2'(w), 4'd0});
    chk({tag, " issue addr"}, 64'(bus.mem_req_addr), 64'(addr_m[w]));
    chk({tag, " issue wdata"}, bus.mem_req_wdata, wdata_m[w]);
    for (int d = 0; d < rdy_dly; d++) begin
      tick();
      chk({tag, " hold"}, {bus.mem_req_valid, 2'(bus.mem_req_core), 21'(bus.mem_req_addr)},
          {1'b1, 2'(w), addr_m[w]});
      chk({tag, " hold wdata"}, bus.mem_req_wdata, wdata_m[w]);
    end
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    chk({tag, " wait entry"}, {62'd0, bus.mem_req_valid, bus.busy}, 64'd1);
    to   = (k < 0) || (k >= TO);
    endi = to ? TO - 1 : k;
    for (int i = 0; i <= endi; i++) begin
      if (i == k) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = rd;
      end
      tick();
      bus.mem_resp_valid = 1'b0;
      if (i < endi) chk({tag, " early resp"}, 64'(bus.resp_valid), 64'd0);
    end
    chk({tag, " resp route"}, 64'(bus.resp_valid), 64'(1) << w);
    chk({tag, " resp err"}, 64'(bus.resp_err), 64'(to));
    chk({tag, " resp data"}, bus.resp_rdata, to ? 64'd0 : rd);
    ptr = (w + 1) % NC;
    tick();
    if (to && k >= 0) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_rdata = rd;
      tick();
      bus.mem_resp_valid = 1'b0;
    end
    chk_quiet(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset              = 1'b1;
    bus.req_valid      = '0;
    bus.req_write      = '0;
    bus.req_addr       = '0;
    bus.req_wdata      = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
    tick();
    tick();
    chk("reset ctl", {bus.busy, bus.mem_req_valid, bus.mem_req_write, bus.resp_err,
                      bus.req_ready, bus.resp_valid, bus.mem_req_core}, '0);
    chk("reset addr", 64'(bus.mem_req_addr), 64'd0);
    chk("reset data", bus.mem_req_wdata | bus.resp_rdata, 64'd0);
    reset = 1'b0;
    tick();
    chk_quiet("post reset");

    for (int n = 0; n < 12; n++) begin
      chk("rotation", 64'(pick(4'hF, ptr)), 64'(n % NC));
      txn(4'hF, 0, 1, 1'b0, "contention");
    end

    txn(4'b0100, 0, 0, 1'b1, "single read");

    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 64'h1234;
    tick();
    bus.mem_resp_valid = 1'b0;
    chk_quiet("stray resp");

    txn(4'b0001, 5, 2, 1'b0, "backpressure");
    txn(4'b0010, 0, TO + 4, 1'b0, "timeout");
    txn(4'b1000, 1, TO - 1, 1'b0, "race");

    bus.req_valid = 4'b0001;
    #1;
    bus.req_valid = '0;
    tick();
    chk_quiet("withdrawn req");

    for (int n = 0; n < 25; n++)
      txn(4'($urandom_range(1, 15)), $urandom_range(0, 3),
          ($urandom_range(0, 7) == 0) ? TO + 1 : $urandom_range(0, TO - 1), 1'b0, "random");

    txn(4'b0100, 0, 1, 1'b0, "pre reset");
    bus.req_valid = 4'b0010;
    #1;
    chk("midwait grant", 64'(bus.req_ready), 64'b0010);
    tick();
    bus.req_valid     = '0;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midwait reset", {bus.busy, bus.mem_req_valid, bus.resp_err, bus.req_ready, bus.resp_valid}, '0);
    bus.mem_resp_valid = 1'b1;
    tick();
    bus.mem_resp_valid = 1'b0;
    chk_quiet("late after reset");
    ptr = 0;
    txn(4'b1010, 0, 0, 1'b0, "ptr cleared");
    txn(4'b1000, 0, 0, 1'b0, "core3 after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
